if_fetch_unit: RTL and testbench

//  Parametrised successor to the fixed single-cycle fetch stage. It talks to an instruction memory

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the inst SRAM bridge.
// Split request/response handshake:
//   req, addr, wr, size, wstrb, wdata : request from fetch (accepted when req & addr_ok)
//   addr_ok                           : memory accepts the request this cycle
//   data_ok, rdata                    : one in-order response this cycle
// Modports: master = fetch unit side, slave = memory side.
interface if_fetch_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with multiple outstanding memory requests.
// Issues word reads to the inst SRAM, remembers the pc of each request in flight,
// buffers returned instructions and hands them to ID in order. A taken branch redirects
// fetch, flushes the buffer and marks every request still in flight as stale.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   br_bus        : [33] br_stall, [32] br_taken, [31:0] br_target
//   id_allowin    : ID can take an instruction this cycle
//   if_validout   : if_to_id_bus holds a valid instruction
//   if_to_id_bus  : {inst, pc} of the buffer head
//   inst_sram     : memory request/response bus (master side)
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET        = 32'h1c000000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BUF_DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [33:0]            br_bus,
  input  logic                   id_allowin,
  output logic                   if_validout,
  output logic [63:0]            if_to_id_bus,
  if_fetch_unit_if.master        inst_sram
);

  localparam int unsigned CntW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PendPtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned BufPtrW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned BufCntW  = $clog2(BUF_DEPTH + 1);
  // Storage is rounded up to the pointer range so every pointer value indexes a real slot.
  localparam int unsigned PendSlots = 2 ** PendPtrW;
  localparam int unsigned BufSlots  = 2 ** BufPtrW;

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  assign {br_stall, br_taken, br_target} = br_bus;

  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         pend_pc_q [PendSlots];
  logic [PendPtrW-1:0] pend_wr_q, pend_rd_q;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic [CntW-1:0]     cancel_cnt_q, cancel_cnt_d;
  logic [63:0]         buf_q [BufSlots];
  logic [BufPtrW-1:0]  buf_wr_q, buf_rd_q;
  logic [BufCntW-1:0]  buf_cnt_q, buf_cnt_d;

  logic        req;
  logic        hs;
  logic        dok;
  logic        discard;
  logic        buf_push;
  logic        buf_pop;
  logic [31:0] reserved;

  function automatic logic [PendPtrW-1:0] pend_inc(logic [PendPtrW-1:0] p);
    return (p == PendPtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + PendPtrW'(1);
  endfunction

  function automatic logic [BufPtrW-1:0] buf_inc(logic [BufPtrW-1:0] p);
    return (p == BufPtrW'(BUF_DEPTH - 1)) ? '0 : p + BufPtrW'(1);
  endfunction

  // Buffer slots already spoken for: live (non-cancelled) responses plus held instructions.
  assign reserved = 32'(inflight_q) - 32'(cancel_cnt_q) + 32'(buf_cnt_q);
  assign req = ~rst & ~br_stall & (32'(inflight_q) < MAX_OUTSTANDING) & (reserved < BUF_DEPTH);

  assign inst_sram.req   = req;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'b0000;
  assign inst_sram.addr  = fetch_pc_q;
  assign inst_sram.wdata = 32'h0;

  assign hs          = req & inst_sram.addr_ok;
  assign dok         = inst_sram.data_ok;
  assign discard     = dok & (cancel_cnt_q != '0);
  assign buf_push    = dok & ~discard & ~br_taken;
  assign if_validout = ~rst & (buf_cnt_q != '0) & ~br_taken;
  assign buf_pop     = if_validout & id_allowin;
  assign if_to_id_bus = buf_q[buf_rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (br_taken) begin
      fetch_pc_d = br_target;
    end else if (hs) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    inflight_d = inflight_q;
    if (hs) inflight_d = inflight_d + CntW'(1);
    if (dok) inflight_d = inflight_d - CntW'(1);

    // Everything still in flight after a redirect carries an old pc.
    cancel_cnt_d = cancel_cnt_q;
    if (br_taken) begin
      cancel_cnt_d = inflight_d;
    end else if (discard) begin
      cancel_cnt_d = cancel_cnt_q - CntW'(1);
    end

    buf_cnt_d = buf_cnt_q;
    if (br_taken) begin
      buf_cnt_d = '0;
    end else begin
      if (buf_push) buf_cnt_d = buf_cnt_d + BufCntW'(1);
      if (buf_pop) buf_cnt_d = buf_cnt_d - BufCntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= PC_RESET;
      inflight_q   <= '0;
      cancel_cnt_q <= '0;
      buf_cnt_q    <= '0;
      pend_wr_q    <= '0;
      pend_rd_q    <= '0;
      buf_wr_q     <= '0;
      buf_rd_q     <= '0;
      for (int i = 0; i < int'(PendSlots); i++) pend_pc_q[i] <= '0;
      for (int i = 0; i < int'(BufSlots); i++) buf_q[i] <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      cancel_cnt_q <= cancel_cnt_d;
      buf_cnt_q    <= buf_cnt_d;
      if (hs) begin
        pend_pc_q[pend_wr_q] <= fetch_pc_q;
        pend_wr_q            <= pend_inc(pend_wr_q);
      end
      if (dok) begin
        pend_rd_q <= pend_inc(pend_rd_q);
      end
      if (buf_push) begin
        buf_q[buf_wr_q] <= {inst_sram.rdata, pend_pc_q[pend_rd_q]};
        buf_wr_q        <= buf_inc(buf_wr_q);
      end
      // Flush: no push happens on a branch cycle, so the write pointer is the new empty head.
      if (br_taken) begin
        buf_rd_q <= buf_wr_q;
      end else if (buf_pop) begin
        buf_rd_q <= buf_inc(buf_rd_q);
      end
    end
  end

  // Memory must never answer when nothing is outstanding.
  data_ok_has_request: assert property (@(posedge clk) disable iff (rst)
    !(inst_sram.data_ok && (inflight_q == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam logic [31:0] PcReset = 32'h1c000000;
  localparam int NCfg = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [33:0] br_bus = '0;
  logic        id_allowin = 1'b0;
  int          mode = 0;       // 0: addr_ok always, fixed latency; 1: random
  int          lat_fixed = 1;
  int          cyc = 0;
  logic        live_chk = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  // Taps on configuration 0 (MAX_OUTSTANDING=2, BUF_DEPTH=2) for directed checks.
  logic        req0, valid0, dok0;
  logic [63:0] bus0;
  logic [31:0] addr0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NCfg; g++) begin : g_cfg
    localparam int unsigned Mo = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int unsigned Bd = (g == 0) ? 2 : (g == 2) ? 1 : 4;

    if_fetch_unit_if sram_if ();
    logic        validout;
    logic [63:0] to_id;

    if_fetch_unit #(
      .PC_RESET       (PcReset),
      .MAX_OUTSTANDING(Mo),
      .BUF_DEPTH      (Bd)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .br_bus      (br_bus),
      .id_allowin  (id_allowin),
      .if_validout (validout),
      .if_to_id_bus(to_id),
      .inst_sram   (sram_if)
    );

    if (g == 0) begin : g_tap
      assign req0   = sram_if.req;
      assign valid0 = validout;
      assign dok0   = sram_if.data_ok;
      assign bus0   = to_id;
      assign addr0  = sram_if.addr;
    end

    logic [31:0] q_addr [$];
    int          q_due [$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          pops = 0;

    // Memory: in-order responses, word at address a reads as ~a.
    always @(negedge clk) begin
      sram_if.addr_ok = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (q_due.size() != 0 && q_due[0] <= cyc) begin
        sram_if.data_ok = 1'b1;
        sram_if.rdata   = ~q_addr[0];
      end else begin
        sram_if.data_ok = 1'b0;
        sram_if.rdata   = '0;
      end
    end

    // Reference: requests go out as a +4 stream from the last redirect; ID must see the same
    // stream, restarted at every taken branch, with inst = ~pc.
    always @(posedge clk) begin
      if (rst) begin
        q_addr.delete();
        q_due.delete();
        exp_pc  = PcReset;
        exp_req = PcReset;
      end else begin
        if (sram_if.req && sram_if.addr_ok) begin
          chk("outstanding_limit", 64'(q_addr.size() < int'(Mo)), 64'd1);
          chk("req_addr", 64'(sram_if.addr), 64'(exp_req));
          exp_req = exp_req + 32'd4;
        end
        if (br_bus[33]) chk("req_during_stall", 64'(sram_if.req), 64'd0);
        if (br_bus[32]) exp_req = br_bus[31:0];
        if (sram_if.data_ok) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (sram_if.req && sram_if.addr_ok) begin
          q_addr.push_back(sram_if.addr);
          q_due.push_back(cyc + ((mode == 0) ? lat_fixed : int'($urandom_range(1, 4))));
        end
        if (br_bus[32]) begin
          chk("valid_killed_by_branch", 64'(validout), 64'd0);
          exp_pc = br_bus[31:0];
        end else if (validout && id_allowin) begin
          chk("id_stream", to_id, {~exp_pc, exp_pc});
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
    end

    always @(posedge live_chk) chk("liveness_pops", 64'(pops >= 50), 64'd1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after reset with rst just released.
  task automatic do_reset(input int lat);
    tick();
    rst = 1'b1;
    br_bus = '0;
    id_allowin = 1'b1;
    mode = 0;
    lat_fixed = lat;
    tick();
    #1;
    chk("rst_req", 64'(req0), 64'd0);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_bus", bus0, 64'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [63:0] exp, input int budget);
    for (int n = 0; n < budget && !valid0; n++) tick();
    chk({name, "_valid"}, 64'(valid0), 64'd1);
    chk(name, bus0, exp);
  endtask

  initial begin
    // 1: back-to-back start-up with 1-cycle memory latency
    do_reset(1);
    #1;
    chk("t1_req_c0", 64'(req0), 64'd1);
    chk("t1_addr_c0", 64'(addr0), 64'h1c000000);
    chk("t1_valid_c0", 64'(valid0), 64'd0);
    tick();
    chk("t1_dok_c1", 64'(dok0), 64'd1);
    chk("t1_valid_c1", 64'(valid0), 64'd0);
    tick();
    chk("t1_valid_c2", 64'(valid0), 64'd1);
    chk("t1_bus_c2", bus0, {32'he3ffffff, 32'h1c000000});
    tick();
    chk("t1_valid_c3", 64'(valid0), 64'd1);
    chk("t1_bus_c3", bus0, {32'he3fffffb, 32'h1c000004});
    tick();
    wait_valid("t1_third", {32'he3fffff7, 32'h1c000008}, 5);

    // 2: ID back-pressure fills the buffer and stops requests
    do_reset(1);
    id_allowin = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_req_full", 64'(req0), 64'd0);
    chk("t2_valid_full", 64'(valid0), 64'd1);
    chk("t2_head_full", bus0, {32'he3ffffff, 32'h1c000000});
    id_allowin = 1'b1;
    tick();
    chk("t2_head_next", bus0, {32'he3fffffb, 32'h1c000004});
    for (int i = 0; i < 10; i++) tick();

    // 3: branch with two requests in flight (latency 3)
    do_reset(3);
    #1;
    chk("t3_req_c0", 64'(req0), 64'd1);
    tick();
    chk("t3_req_c1", 64'(req0), 64'd1);
    tick();
    chk("t3_req_c2_limit", 64'(req0), 64'd0);
    br_bus = {1'b0, 1'b1, 32'h1c000100};
    tick();
    br_bus = '0;
    wait_valid("t3_first_after_br", {32'he3fffeff, 32'h1c000100}, 20);
    for (int i = 0; i < 6; i++) tick();

    // 4: branch coinciding with a handshake and a data_ok
    do_reset(1);
    tick();
    br_bus = {1'b0, 1'b1, 32'h1c000200};
    #1;
    chk("t4_req_with_br", 64'(req0), 64'd1);
    chk("t4_dok_with_br", 64'(dok0), 64'd1);
    tick();
    br_bus = '0;
    wait_valid("t4_first_after_br", {32'he3fffdff, 32'h1c000200}, 20);
    for (int i = 0; i < 6; i++) tick();

    // 5: stall holds fetch, then random traffic across all configurations
    do_reset(1);
    tick();
    tick();
    tick();
    br_bus = {1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_req_stalled", 64'(req0), 64'd0);
      if (i != 4) tick();
    end
    tick();
    br_bus = '0;
    #1;
    chk("t5_req_after_stall", 64'(req0), 64'd1);
    chk("t5_addr_after_stall", 64'(addr0), 64'h1c000008);
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tick();
      id_allowin = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 4) == 0) ? 32'hfffffff8 : $urandom();
      br_bus = {($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0), tgt};
    end
    tick();
    br_bus = '0;
    id_allowin = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // 6: reset with two requests in flight
    do_reset(3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_req_in_rst", 64'(req0), 64'd0);
    chk("t6_valid_in_rst", 64'(valid0), 64'd0);
    tick();
    chk("t6_req_after_rst", 64'(req0), 64'd0);
    chk("t6_valid_after_rst", 64'(valid0), 64'd0);
    chk("t6_bus_after_rst", bus0, 64'd0);
    rst = 1'b0;
    #1;
    chk("t6_restart_req", 64'(req0), 64'd1);
    chk("t6_restart_addr", 64'(addr0), 64'h1c000000);
    tick();
    wait_valid("t6_first_after_rst", {32'he3ffffff, 32'h1c000000}, 10);
    for (int i = 0; i < 10; i++) tick();

    live_chk = 1'b1;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
